// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state type,
// parameter defaults and a helper for sizing the mul/div wait counter.
package hazard_pkg;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_e;

    localparam int MD_TIMEOUT_DEFAULT = 64;
    localparam int CNT_W_DEFAULT      = 32;

    // Width needed to hold values 0..timeout, never less than one bit.
    function automatic int waitWidth(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hazard_compare.sv
// Load-use detector: flags an ID-stage instruction that reads the register
// a load currently in EX is about to write. Register x0 never hazards.
module hazard_compare
    import hazard_pkg::*;
(
    input  logic       load_ex_i,
    input  logic [4:0] rd_ex_i,
    input  logic [4:0] rs1_id_i,
    input  logic [4:0] rs2_id_i,
    input  logic       rs1_used_id_i,
    input  logic       rs2_used_id_i,
    output logic       load_use_hit_o
);

    logic rs1Match;
    logic rs2Match;

    // Compare each used source against the load destination.
    always_comb begin
        rs1Match       = rs1_used_id_i && (rs1_id_i == rd_ex_i);
        rs2Match       = rs2_used_id_i && (rs2_id_i == rd_ex_i);
        load_use_hit_o = load_ex_i && (rd_ex_i != 5'd0) && (rs1Match || rs2Match);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: resolves taken branches, load-use stalls and
// multi-cycle multiply/divide freezes, with a mul/div watchdog and a
// saturating stall-cycle counter.
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_ex,
    input  logic [4:0]       rd_ex,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic             muldiv_req_ex,
    input  logic             muldiv_done,
    input  logic             branch_taken_ex,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             muldiv_start,
    output logic             md_timeout_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                WAIT_W    = waitWidth(MD_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STALL_MAX = '1;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              loadUseHit;
    logic              startRaw;

    hazard_compare u_compare (
        .load_ex_i      (load_ex),
        .rd_ex_i        (rd_ex),
        .rs1_id_i       (rs1_id),
        .rs2_id_i       (rs2_id),
        .rs1_used_id_i  (rs1_used_id),
        .rs2_used_id_i  (rs2_used_id),
        .load_use_hit_o (loadUseHit)
    );

    // Next-state and Mealy output logic; branch beats mul/div beats load-use.
    always_comb begin
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        id_ex_we      = 1'b1;
        ex_mem_we     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        startRaw      = 1'b0;
        state_d       = state_q;
        wait_d        = wait_q;
        err_d         = err_q;
        case (state_q)
            ST_RUN: begin
                if (branch_taken_ex) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (muldiv_req_ex) begin
                    startRaw      = 1'b1;
                    pc_we         = 1'b0;
                    if_id_we      = 1'b0;
                    id_ex_we      = 1'b0;
                    ex_mem_we     = 1'b0;
                    ex_mem_bubble = 1'b1;
                    state_d       = ST_MD_WAIT;
                    wait_d        = '0;
                end else if (loadUseHit) begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (muldiv_done) begin
                    state_d = ST_RUN;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_RUN;
                    err_d   = 1'b1;
                end else begin
                    pc_we         = 1'b0;
                    if_id_we      = 1'b0;
                    id_ex_we      = 1'b0;
                    ex_mem_we     = 1'b0;
                    ex_mem_bubble = 1'b1;
                    wait_d        = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        muldiv_start = startRaw && !reset;
        stall_d      = (!pc_we && (stall_q != STALL_MAX)) ? stall_q + CNT_W'(1) : stall_q;
    end

    // State, watchdog, sticky error and stall counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign md_timeout_err = err_q;
    assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances (default parameters and
// a short-timeout / narrow-counter variant) share stimulus and are compared
// against a behavioural model, fixed vectors and hand-written sequences.
module tb_pipeline_hazard_controller;

    localparam int TO0 = 64;
    localparam int W0  = 32;
    localparam int TO1 = 8;
    localparam int W1  = 4;

    typedef struct {
        logic       ld;
        logic [4:0] rd;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic       mreq;
        logic       mdone;
        logic       br;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_ex;
    logic [4:0] rd_ex, rs1_id, rs2_id;
    logic       rs1_used_id, rs2_used_id;
    logic       muldiv_req_ex, muldiv_done, branch_taken_ex;

    logic pcWe[2], ifIdWe[2], idExWe[2], exMemWe[2];
    logic ifIdFlush[2], idExBubble[2], exMemBubble[2], mdStart[2], mdErr[2];
    logic [W0-1:0] stall0;
    logic [W1-1:0] stall1;

    int checks = 0;
    int errors = 0;

    // Behavioural model state, one slot per instance.
    bit     mBusy[2];
    int     mWaited[2];
    bit     mErr[2];
    longint mStall[2];
    bit     mPc[2];
    int     mTo[2];
    longint mMax[2];

    bit countOn = 0;
    int startCnt = 0;
    int frozenCnt = 0;

    vec_t vecs[11];

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.MD_TIMEOUT(TO0), .CNT_W(W0)) dut0 (
        .clk(clk), .reset(reset), .load_ex(load_ex), .rd_ex(rd_ex),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id),
        .rs2_used_id(rs2_used_id), .muldiv_req_ex(muldiv_req_ex),
        .muldiv_done(muldiv_done), .branch_taken_ex(branch_taken_ex),
        .pc_we(pcWe[0]), .if_id_we(ifIdWe[0]), .id_ex_we(idExWe[0]),
        .ex_mem_we(exMemWe[0]), .if_id_flush(ifIdFlush[0]),
        .id_ex_bubble(idExBubble[0]), .ex_mem_bubble(exMemBubble[0]),
        .muldiv_start(mdStart[0]), .md_timeout_err(mdErr[0]),
        .stall_cycles(stall0)
    );

    pipeline_hazard_controller #(.MD_TIMEOUT(TO1), .CNT_W(W1)) dut1 (
        .clk(clk), .reset(reset), .load_ex(load_ex), .rd_ex(rd_ex),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id),
        .rs2_used_id(rs2_used_id), .muldiv_req_ex(muldiv_req_ex),
        .muldiv_done(muldiv_done), .branch_taken_ex(branch_taken_ex),
        .pc_we(pcWe[1]), .if_id_we(ifIdWe[1]), .id_ex_we(idExWe[1]),
        .ex_mem_we(exMemWe[1]), .if_id_flush(ifIdFlush[1]),
        .id_ex_bubble(idExBubble[1]), .ex_mem_bubble(exMemBubble[1]),
        .muldiv_start(mdStart[1]), .md_timeout_err(mdErr[1]),
        .stall_cycles(stall1)
    );

    function automatic vec_t mkVec(logic ld, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                                   logic u1, logic u2, logic mreq, logic mdone, logic br,
                                   logic [7:0] exp);
        vec_t v;
        v.ld = ld; v.rd = rd; v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2;
        v.mreq = mreq; v.mdone = mdone; v.br = br; v.exp = exp;
        return v;
    endfunction

    // Expected {pc_we,if_id_we,id_ex_we,ex_mem_we,if_id_flush,id_ex_bubble,ex_mem_bubble,muldiv_start}
    function automatic logic [7:0] expectOut(int m);
        logic pc, ifid, idex, exm, fl, idb, exb, st;
        bit hit;
        pc = 1; ifid = 1; idex = 1; exm = 1; fl = 0; idb = 0; exb = 0; st = 0;
        hit = load_ex && (rd_ex != 0) &&
              ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
        if (mBusy[m]) begin
            if (!(muldiv_done || mWaited[m] == mTo[m] - 1)) begin
                pc = 0; ifid = 0; idex = 0; exm = 0; exb = 1;
            end
        end else if (branch_taken_ex) begin
            fl = 1; idb = 1;
        end else if (muldiv_req_ex) begin
            pc = 0; ifid = 0; idex = 0; exm = 0; exb = 1; st = !reset;
        end else if (hit) begin
            pc = 0; ifid = 0; idb = 1;
        end
        return {pc, ifid, idex, exm, fl, idb, exb, st};
    endfunction

    task automatic checkOutput(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        load_ex = v.ld; rd_ex = v.rd; rs1_id = v.r1; rs2_id = v.r2;
        rs1_used_id = v.u1; rs2_used_id = v.u2;
        muldiv_req_ex = v.mreq; muldiv_done = v.mdone; branch_taken_ex = v.br;
    endtask

    task automatic idleInputs();
        applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    endtask

    // One clock: compare at the falling edge, then advance the model on the rising edge.
    task automatic tick(input logic [1:0] vecMask, input logic [7:0] vecExp);
        logic [7:0] got;
        logic [7:0] exp;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            got = {pcWe[m], ifIdWe[m], idExWe[m], exMemWe[m],
                   ifIdFlush[m], idExBubble[m], exMemBubble[m], mdStart[m]};
            exp = expectOut(m);
            mPc[m] = exp[7];
            checkOutput($sformatf("model outputs dut%0d", m), got, exp);
            checkOutput($sformatf("model stall dut%0d", m), (m == 0) ? longint'(stall0) : longint'(stall1), mStall[m]);
            checkOutput($sformatf("model err dut%0d", m), mdErr[m], mErr[m]);
            if (vecMask[m]) checkOutput($sformatf("vector outputs dut%0d", m), got, vecExp);
        end
        if (countOn) begin
            if (mdStart[0]) startCnt++;
            if (!pcWe[0]) frozenCnt++;
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                mBusy[m] = 0; mWaited[m] = 0; mErr[m] = 0; mStall[m] = 0;
            end else begin
                if (!mPc[m] && mStall[m] < mMax[m]) mStall[m]++;
                if (mBusy[m]) begin
                    if (muldiv_done) mBusy[m] = 0;
                    else if (mWaited[m] == mTo[m] - 1) begin mBusy[m] = 0; mErr[m] = 1; end
                    else mWaited[m]++;
                end else if (!branch_taken_ex && muldiv_req_ex) begin
                    mBusy[m] = 1; mWaited[m] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic resetCycle();
        reset = 1; idleInputs();
        tick(2'b00, 8'h00);
        reset = 0;
    endtask

    initial begin
        mTo[0] = TO0; mTo[1] = TO1;
        mMax[0] = (longint'(1) << W0) - 1;
        mMax[1] = (longint'(1) << W1) - 1;
        for (int m = 0; m < 2; m++) begin
            mBusy[m] = 0; mWaited[m] = 0; mErr[m] = 0; mStall[m] = 0; mPc[m] = 1;
        end

        vecs[0]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1111_0000);
        vecs[1]  = mkVec(1, 5, 5, 0, 1, 0, 0, 0, 0, 8'b0011_0100);
        vecs[2]  = mkVec(1, 0, 3, 0, 0, 1, 0, 0, 0, 8'b1111_0000);
        vecs[3]  = mkVec(1, 7, 1, 7, 0, 1, 0, 0, 0, 8'b0011_0100);
        vecs[4]  = mkVec(1, 7, 7, 2, 0, 0, 0, 0, 0, 8'b1111_0000);
        vecs[5]  = mkVec(0, 7, 7, 7, 1, 1, 0, 0, 0, 8'b1111_0000);
        vecs[6]  = mkVec(1, 5, 5, 0, 1, 0, 0, 0, 1, 8'b1111_1100);
        vecs[7]  = mkVec(1, 5, 5, 0, 1, 0, 1, 0, 0, 8'b0000_0011);
        vecs[8]  = mkVec(0, 0, 0, 0, 0, 0, 1, 0, 1, 8'b1111_1100);
        vecs[9]  = mkVec(0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b1111_0000);
        vecs[10] = mkVec(0, 0, 0, 0, 0, 0, 1, 1, 0, 8'b0000_0011);

        reset = 1; idleInputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        checkOutput("reset stall0", stall0, 0);
        checkOutput("reset stall1", stall1, 0);
        checkOutput("reset err0", mdErr[0], 0);
        checkOutput("reset start0", mdStart[0], 0);
        checkOutput("reset pc_we0", pcWe[0], 1);

        // Single-cycle vectors, each from a fresh reset.
        for (int i = 0; i < 11; i++) begin
            resetCycle();
            applyStimulus(vecs[i]);
            tick(2'b11, vecs[i].exp);
        end

        // Single load-use stall counts exactly one cycle.
        resetCycle();
        applyStimulus(vecs[1]);
        tick(2'b11, 8'b0011_0100);
        idleInputs();
        tick(2'b11, 8'b1111_0000);
        checkOutput("load-use stall count", stall0, 1);

        // Mul/div with done arriving after 34 frozen cycles.
        resetCycle();
        countOn = 1; startCnt = 0; frozenCnt = 0;
        muldiv_req_ex = 1;
        for (int k = 0; k < 34; k++) tick(2'b00, 8'h00);
        muldiv_done = 1;
        tick(2'b01, 8'b1111_0000);
        countOn = 0;
        idleInputs();
        checkOutput("muldiv start pulses", startCnt, 1);
        checkOutput("muldiv frozen cycles", frozenCnt, 34);
        checkOutput("muldiv stall count", stall0, 34);
        tick(2'b01, 8'b1111_0000);

        // Watchdog on the short-timeout instance, then a late done is ignored.
        resetCycle();
        muldiv_req_ex = 1;
        tick(2'b10, 8'b0000_0011);
        muldiv_req_ex = 0;
        for (int k = 0; k < 7; k++) tick(2'b10, 8'b0000_0010);
        tick(2'b10, 8'b1111_0000);
        checkOutput("timeout err set", mdErr[1], 1);
        checkOutput("timeout stall count", stall1, 8);
        tick(2'b10, 8'b1111_0000);
        muldiv_done = 1;
        tick(2'b10, 8'b1111_0000);
        muldiv_done = 0;
        tick(2'b10, 8'b1111_0000);
        checkOutput("timeout err held", mdErr[1], 1);

        // Reset during the third wait cycle, followed by a late done.
        resetCycle();
        muldiv_req_ex = 1;
        tick(2'b11, 8'b0000_0011);
        muldiv_req_ex = 0;
        tick(2'b11, 8'b0000_0010);
        tick(2'b11, 8'b0000_0010);
        reset = 1;
        tick(2'b11, 8'b0000_0010);
        reset = 0;
        muldiv_done = 1;
        tick(2'b11, 8'b1111_0000);
        muldiv_done = 0;
        checkOutput("post-reset stall0", stall0, 0);
        checkOutput("post-reset err0", mdErr[0], 0);

        // Narrow stall counter saturates at all-ones.
        resetCycle();
        applyStimulus(vecs[3]);
        for (int k = 0; k < 20; k++) tick(2'b00, 8'h00);
        idleInputs();
        checkOutput("stall saturate dut1", stall1, 15);
        checkOutput("stall no-saturate dut0", stall0, 20);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            reset           = ($urandom_range(0, 63) == 0);
            load_ex         = 1'($urandom_range(0, 1));
            rd_ex           = 5'($urandom_range(0, 7));
            rs1_id          = 5'($urandom_range(0, 7));
            rs2_id          = 5'($urandom_range(0, 7));
            rs1_used_id     = 1'($urandom_range(0, 1));
            rs2_used_id     = 1'($urandom_range(0, 1));
            muldiv_req_ex   = ($urandom_range(0, 7) == 0);
            muldiv_done     = ($urandom_range(0, 11) == 0);
            branch_taken_ex = ($urandom_range(0, 4) == 0);
            tick(2'b00, 8'h00);
        end
        reset = 0; idleInputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
